// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory-side blocks.
//   word_t      - 32-bit data/address word
//   ramstate_t  - RAM status reported back to the memory controller
//   BAD_WORD    - read data returned for an address outside the array
//   ram_in_range- true when a byte address falls inside a DEPTH-word array
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam word_t BAD_WORD = 32'hBAD1BAD1;

  // Compare on the word address so DEPTH*4 never has to fit in 32 bits.
  function automatic logic ram_in_range(word_t addr, int unsigned depth);
    return (addr >> 2) < word_t'(depth);
  endfunction

endpackage

// File: rtl/ram_wait_ctrl_if.sv
// ram_wait_ctrl_if: request/response bundle between the memory controller
// and the RAM model.
//   ramREN/ramWEN  - level read/write requests, held until ACCESS
//   ramaddr        - byte address
//   ramstore       - write data
//   ramload        - read data
//   ramstate       - FREE / BUSY / ACCESS / ERROR
// master = controller side, slave = RAM side.
interface ram_wait_ctrl_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_wait_ctrl_array.sv
// ram_array: DEPTH x 32-bit storage, one synchronous write port with enable
// and one asynchronous read port. No reset: contents survive RST.
//   CLK   - clock
//   we    - write enable (sampled on rising edge)
//   waddr - write word index
//   wdata - write data
//   raddr - read word index
//   rdata - combinational read data
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl: word-addressed RAM with LAT wait states, modelling the
// system RAM seen by the memory controller. A request seen in cycle 0 gets
// BUSY for cycles 0..LAT and ACCESS in cycle LAT+1. Changing the address or
// request type while waiting restarts the count; REN and WEN together is
// reported as ERROR. Out-of-range reads return BAD_WORD, out-of-range writes
// are dropped, both still complete with ACCESS.
//   CLK  - clock, all state changes on rising edge
//   RST  - synchronous active-high reset
//   ram  - slave side of ram_wait_ctrl_if (requests in, ramload/ramstate out)
// Parameters: LAT (0..15) wait states, DEPTH (power of two) words.
module ram_wait_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  ram_wait_ctrl_if.slave ram
);

  localparam int AW = $clog2(DEPTH);
  // Counter value loaded on (re)start; COUNT leaves when it reaches zero.
  localparam logic [3:0] CNT_LOAD = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t    state, state_n;
  logic [3:0] cnt, cnt_n;
  word_t     addr_q, addr_n;
  logic      ren_q, ren_n;
  logic      wen_q, wen_n;
  word_t     load_q, load_n;
  ramstate_t rstate;

  logic      req_one, req_both, req_none, changed, start;
  logic      we;
  word_t     rdata;

  assign req_both = ram.ramREN & ram.ramWEN;
  assign req_one  = ram.ramREN ^ ram.ramWEN;
  assign req_none = ~(ram.ramREN | ram.ramWEN);
  assign changed  = (ram.ramaddr != addr_q) || (ram.ramREN != ren_q) ||
                    (ram.ramWEN != wen_q);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    ren_n   = ren_q;
    wen_n   = wen_q;
    load_n  = load_q;
    rstate  = FREE;
    start   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_both) begin
          rstate = ERROR;
        end else if (req_one) begin
          rstate = BUSY;
          start  = 1'b1;
        end
      end
      COUNT: begin
        rstate = BUSY;
        if (req_both) begin
          rstate  = ERROR;
          state_n = IDLE;
        end else if (req_none) begin
          state_n = IDLE;
        end else if (changed) begin
          // Restart takes priority over an expiring counter.
          start = 1'b1;
        end else if (cnt == 4'd0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        // Inputs are not examined here; always one IDLE cycle afterwards.
        rstate  = ACCESS;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      addr_n  = ram.ramaddr;
      ren_n   = ram.ramREN;
      wen_n   = ram.ramWEN;
      cnt_n   = CNT_LOAD;
      state_n = (LAT == 0) ? DONE : COUNT;
    end

    // Read data is captured on the edge entering DONE so it is stable for
    // the whole ACCESS cycle and held afterwards.
    if (state != DONE && state_n == DONE && ren_n) begin
      load_n = ram_in_range(addr_n, DEPTH) ? rdata : BAD_WORD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      ren_q  <= 1'b0;
      wen_q  <= 1'b0;
      load_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      ren_q  <= ren_n;
      wen_q  <= wen_n;
      load_q <= load_n;
    end
  end

  // The array has no reset, so a reset in DONE must gate the write here.
  assign we = (state == DONE) && wen_q && ram_in_range(addr_q, DEPTH) && !RST;

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .we    (we),
    .waddr (addr_q[AW+1:2]),
    .wdata (ram.ramstore),
    .raddr (addr_n[AW+1:2]),
    .rdata (rdata)
  );

  assign ram.ramstate = rstate;
  assign ram.ramload  = load_q;

endmodule

// File: doc/ram_wait_ctrl.md
# ram_wait_ctrl

Word-addressed RAM with a programmable access latency. It sits directly downstream of the memory controller and is the only consumer of its `ram*` request signals. It produces the `ramstate`/`ramload` pair that the controller polls for `ACCESS`. The block models the wait states and the address-change restarts of the system RAM, so controller write-back, load and cache-to-cache sequences run against realistic timing.

## Interface
- `LAT`, default 2: wait states before `ACCESS`; legal range 0..15.
- `DEPTH`, default 1024: number of 32-bit words stored; power of two.
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST`  in  1  reset; one clock, reset is synchronous and active-high.
- `ramREN`  in  1  read request; level, held until `ACCESS` is seen.
- `ramWEN`  in  1  write request; level, held until `ACCESS` is seen.
- `ramaddr`  in  32  byte address; bits [1:0] ignored.
- `ramstore`  in  32  write data; sampled in the `ACCESS` cycle.
- `ramload`  out  32  read data; valid in the `ACCESS` cycle of a read.
- `ramstate`  out  2  `ramstate_t`: `FREE`, `BUSY`, `ACCESS`, `ERROR`.

## Operation
- State machine `IDLE`, `COUNT`, `DONE`; registers `cnt` (4 b), `addr_q`, `ren_q`, `wen_q`.
- **IDLE**
  - No request: `ramstate=FREE`.
  - Exactly one of REN/WEN: `ramstate=BUSY`; latch `addr_q`/`ren_q`/`wen_q`.
    - `LAT=0`: next state `DONE`.
    - Otherwise: next state `COUNT` with `cnt=LAT-1`.
  - Both REN and WEN: `ramstate=ERROR`; stay `IDLE`, nothing latched.
- **COUNT**: `ramstate=BUSY`.
  - Request dropped: go to `IDLE`.
  - Both REN and WEN: `ramstate=ERROR`, go to `IDLE`.
  - `ramaddr`, REN or WEN differs from the latched copy: restart. Relatch, reload `cnt` exactly as from `IDLE`, and the cycle counts as a fresh cycle 0.
  - Otherwise: if `cnt==0` go to `DONE`, else decrement `cnt`.
- **DONE**: `ramstate=ACCESS` for exactly one cycle, then `IDLE` unconditionally.
  - Read: `ramload` shows the value captured on entry to `DONE`.
  - Write: array written at the rising edge that ends `DONE`, using `ramstore` and `addr_q`.
  - The `ramaddr`/`ramREN`/`ramWEN` inputs are not re-checked in this cycle.
- Index = `addr_q[log2(DEPTH)+1:2]`.
  - Address ≥ `DEPTH*4` on a read: `ramload = BAD_WORD`.
  - Address ≥ `DEPTH*4` on a write: the write is dropped.
  - In both cases `ACCESS` is still given.
- `ramload` holds its last captured value outside `ACCESS`.

## Timing
- Request first seen in cycle 0 (state `IDLE`): `ACCESS` in cycle `LAT+1`, `BUSY` in cycles 0..`LAT`.
- Back-to-back requests:
  - After `DONE` the block always spends one `IDLE` cycle, which shows `BUSY` if a request is present.
  - Minimum period is therefore `LAT+2` cycles.
- A request still asserted after its `ACCESS` cycle is treated as a new transaction. The controller must deassert or change the request on the edge that ends `ACCESS`.
- Reset values:
  - state `IDLE`, `cnt=0`, latched request cleared.
  - `ramload=0`; `ramstate=FREE` in the cycle after reset when no request is present.
  - Array contents are not cleared.
- Reset mid-`COUNT`: the transaction is discarded. Reset during `DONE`: the pending write is not performed.
- Simultaneous restart and `cnt==0` in `COUNT`: the restart wins.

## Structure
- `cpu_types_pkg` holds:
  - `ramstate_t` (`FREE`, `BUSY`, `ACCESS`, `ERROR`) and `word_t`.
  - New constant `BAD_WORD = 32'hBAD1BAD1`.
- Local `typedef enum` for `IDLE`/`COUNT`/`DONE` stays inside the module.
- One sub-module, `ram_array`: DEPTH×32 storage with a single write port (sync, enable) and an async read port, parameterised on `DEPTH`. `ram_wait_ctrl` owns all timing and range checks.

## Test plan
- `LAT=2`, write `0x0000_0040` ← `0xDEADBEEF`:
  - `ramstate` is `BUSY` for cycles 0–2 and `ACCESS` in cycle 3.
  - A read of `0x40` then returns `0xDEADBEEF` with `ACCESS` in cycle 3 of the read.
- `LAT=2`, read `0x40`; in cycle 1 change `ramaddr` to `0x44` → counter restarts, and `ACCESS` lands in cycle 4 with the data of word `0x44`.
- REN and WEN both high in `IDLE` → `ramstate=ERROR` each cycle, no array write, no `ACCESS`.
- Read `0x0000_1000` with `DEPTH=1024` → `ACCESS` with `ramload=0xBAD1BAD1`. A write to the same address leaves word 0 unchanged.
- `LAT=0`, two consecutive reads of `0x0` and `0x4`, with the controller changing the address on each `ACCESS` edge → `ACCESS` in cycles 1 and 3.
- `LAT=3`, write `0x8` ← `0x1234`:
  - Assert `RST` in cycle 2 → state `IDLE`, `ramload=0`, `ramstate` is `FREE` once REN/WEN are low.
  - A later read of `0x8` returns the prior contents, not `0x1234`.
